// File: rtl/mac_pkg.sv
// Shared MAC filter definitions: hit codes, broadcast address, FSM states.
// Hit priority helper used by the decision stage.
package mac_pkg;

   localparam logic [1:0] HIT_NONE  = 2'b00;
   localparam logic [1:0] HIT_UCAST = 2'b01;
   localparam logic [1:0] HIT_MCAST = 2'b10;
   localparam logic [1:0] HIT_BCAST = 2'b11;

   localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DA0,
      ST_DA1,
      ST_DA2,
      ST_DECIDE,
      ST_HOLD
   } state_t;

   function automatic logic [1:0] hit_sel(
      input logic bc,
      input logic uc,
      input logic mc
   );
      logic [1:0] h;
      h = HIT_NONE;
      if (bc)
         h = HIT_BCAST;
      else if (uc)
         h = HIT_UCAST;
      else if (mc)
         h = HIT_MCAST;
      return h;
   endfunction

endpackage

// File: rtl/mc_table.sv
// Multicast address table: register array with one write port
// and a parallel compare of every enabled entry against the DA.
module mc_table
   import mac_pkg::*;
#(
   parameter int ENTRIES = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_wr,
   input  logic [2:0]  i_idx,
   input  logic [47:0] i_addr,
   input  logic        i_en,
   input  logic [47:0] i_da,
   output logic        o_hit
);

   localparam int         IW       = $clog2(ENTRIES);
   localparam logic [2:0] IDX_MASK = 3'((1 << IW) - 1);

   logic [47:0]        addr_q [ENTRIES];
   logic [ENTRIES-1:0] en_q;
   logic [2:0]         sel;

   // Upper index bits are dropped; out-of-range rows are never written.
   assign sel = i_idx & IDX_MASK;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            addr_q[i] <= '0;
            en_q[i]   <= 1'b0;
         end
      end else if (i_wr) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (int'(sel) == i) begin
               addr_q[i] <= i_addr;
               en_q[i]   <= i_en;
            end
         end
      end
   end

   always_comb begin
      o_hit = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (en_q[i] && (addr_q[i] == i_da))
            o_hit = 1'b1;
      end
   end

endmodule

// File: rtl/rx_filter_ctrl.sv
// Receive address filter: captures the DA, classifies it, issues keep/drop.
// Define RX_FILTER_STATS_EN to add saturating pass/drop frame counters.
module rx_filter_ctrl
   import mac_pkg::*;
#(
   parameter int MC_ENTRIES = 4,
   parameter int CNT_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [15:0]      i_rx_data,
   input  logic [9:0]       i_wordNum,
   input  logic             i_data_valid,
   input  logic             i_recvDn,
   input  logic             i_filter_en,
   input  logic [47:0]      i_local_node_mac,
   input  logic             i_mc_wr,
   input  logic [2:0]       i_mc_idx,
   input  logic [47:0]      i_mc_addr,
   input  logic             i_mc_en,
   output logic             o_recv_keep,
   output logic             o_dec_valid,
   output logic [1:0]       o_hit_type
`ifdef RX_FILTER_STATS_EN
   ,
   input  logic             i_cnt_clr,
   output logic [CNT_W-1:0] o_pass_cnt,
   output logic [CNT_W-1:0] o_drop_cnt
`endif
);

   state_t      state_q;
   state_t      state_d;
   logic [47:0] da_q;
   logic        cap0;
   logic        cap1;
   logic        cap2;
   logic        mc_hit;
   logic        dec_fire;
   logic [1:0]  hit_d;
   logic        keep_d;

   assign cap0 = (state_q == ST_IDLE) && i_data_valid
              && (i_wordNum == 10'd1);
   assign cap1 = (state_q == ST_DA0) && !i_recvDn
              && i_data_valid && (i_wordNum == 10'd2);
   assign cap2 = (state_q == ST_DA1) && !i_recvDn
              && i_data_valid && (i_wordNum == 10'd3);

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cap0)
               state_d = ST_DA0;
         end
         ST_DA0: begin
            if (i_recvDn)
               state_d = ST_IDLE;
            else if (cap1)
               state_d = ST_DA1;
         end
         ST_DA1: begin
            if (i_recvDn)
               state_d = ST_IDLE;
            else if (cap2)
               state_d = ST_DA2;
         end
         ST_DA2: begin
            state_d = i_recvDn ? ST_IDLE : ST_DECIDE;
         end
         ST_DECIDE: begin
            state_d = i_recvDn ? ST_IDLE : ST_HOLD;
         end
         ST_HOLD: begin
            if (i_recvDn)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         da_q <= '0;
      end else begin
         if (cap0) da_q[47:32] <= i_rx_data;
         if (cap1) da_q[31:16] <= i_rx_data;
         if (cap2) da_q[15:0]  <= i_rx_data;
      end
   end

   mc_table #(
      .ENTRIES (MC_ENTRIES)
   ) u_mc_table (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_wr   (i_mc_wr),
      .i_idx  (i_mc_idx),
      .i_addr (i_mc_addr),
      .i_en   (i_mc_en),
      .i_da   (da_q),
      .o_hit  (mc_hit)
   );

   assign dec_fire = (state_q == ST_DECIDE);
   assign hit_d    = hit_sel(da_q == BCAST_ADDR,
                             da_q == i_local_node_mac,
                             mc_hit);
   assign keep_d   = !i_filter_en || (hit_d != HIT_NONE);

   // Decision registers load at the end of DECIDE; keep returns to 1
   // once the frame is over, except for the pulse cycle itself.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_recv_keep <= 1'b1;
         o_dec_valid <= 1'b0;
         o_hit_type  <= HIT_NONE;
      end else begin
         o_dec_valid <= dec_fire;
         if (dec_fire) begin
            o_recv_keep <= keep_d;
            o_hit_type  <= hit_d;
         end else if (state_q == ST_HOLD && !i_recvDn) begin
            o_recv_keep <= o_recv_keep;
         end else begin
            o_recv_keep <= 1'b1;
         end
      end
   end

`ifdef RX_FILTER_STATS_EN
   always_ff @(posedge i_clk) begin
      if (i_rst || i_cnt_clr) begin
         o_pass_cnt <= '0;
         o_drop_cnt <= '0;
      end else if (dec_fire) begin
         if (keep_d) begin
            if (o_pass_cnt != '1)
               o_pass_cnt <= o_pass_cnt + CNT_W'(1);
         end else begin
            if (o_drop_cnt != '1)
               o_drop_cnt <= o_drop_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule
